// File: rtl/spi_regfile_burst_if.sv
// ---------------------------------------------------------------------------
// spi_regfile_burst_if
// SPI mode-0 pin bundle shared by the controller (bench or pad ring) and the
// register-file peripheral.
//   nCS     : chip select, active low          (master -> slave)
//   SCLK    : serial clock                     (master -> slave)
//   COPI    : controller-out data              (master -> slave)
//   cipo    : peripheral-out data              (slave  -> master)
//   cipo_oe : pad output enable for cipo       (slave  -> master)
// ---------------------------------------------------------------------------
interface spi_regfile_burst_if;
  logic nCS;
  logic SCLK;
  logic COPI;
  logic cipo;
  logic cipo_oe;

  modport master (output nCS, SCLK, COPI, input  cipo, cipo_oe);
  modport slave  (input  nCS, SCLK, COPI, output cipo, cipo_oe);
endinterface

// File: rtl/spi_regfile_burst.sv
// ---------------------------------------------------------------------------
// spi_regfile_burst
// SPI mode-0 peripheral owning a NUM_REGS x DATA_W control register file.
// Frame: R/W bit (1 = write), ADDR_W-bit start address, then any number of
// DATA_W-bit words, MSB first. Addresses auto-increment and wrap after
// NUM_REGS-1. Reads return the register value captured when the word is
// loaded into the transmit shifter.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   spi        : SPI pin bundle (slave modport)
//   regs_out   : flat register bus, register k at [k*DATA_W +: DATA_W]
//   wr_strobe  : one-cycle pulse per committed register write
//   wr_addr    : address of that write, valid with wr_strobe
//   frame_err  : one-cycle pulse on a rejected or aborted frame
//   busy       : high while a frame is being processed
// ---------------------------------------------------------------------------
module spi_regfile_burst #(
  parameter int                NUM_REGS  = 9,
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 7,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_burst_if.slave         spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DROP} state_t;

  // Synchronisers. They reset to 0 so that a frame already running when
  // reset is released never produces a falling edge: nCS must first be seen
  // high before the next fall can start a frame.
  logic [2:0] r_ncs_s;
  logic [2:0] r_sclk_s;
  logic [1:0] r_copi_s;

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ncs_s  <= '0;
      r_sclk_s <= '0;
      r_copi_s <= '0;
    end else begin
      r_ncs_s  <= {r_ncs_s[1:0], spi.nCS};
      r_sclk_s <= {r_sclk_s[1:0], spi.SCLK};
      r_copi_s <= {r_copi_s[0], spi.COPI};
    end
  end

  logic w_ncs_fall, w_ncs_rise, w_sclk_rise, w_sclk_fall, w_copi;
  assign w_ncs_fall  = ~r_ncs_s[1] &  r_ncs_s[2];
  assign w_ncs_rise  =  r_ncs_s[1] & ~r_ncs_s[2];
  assign w_sclk_rise =  r_sclk_s[1] & ~r_sclk_s[2];
  assign w_sclk_fall = ~r_sclk_s[1] &  r_sclk_s[2];
  assign w_copi      =  r_copi_s[1];

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [ADDR_W-1:0] r_cmd_sr;
  logic [DATA_W-2:0] r_rx;
  logic [DATA_W-1:0] r_tx;
  logic              r_skip;     // suppress the shift on the fall after a reload
  logic              r_rw;
  logic              r_oe;
  logic              r_busy;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_err;
  logic [IDX_W-1:0]  r_cur;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [ADDR_W:0]   w_cmd_next;
  logic [IDX_W-1:0]  w_a_idx;
  logic              w_addr_bad;
  logic [DATA_W-1:0] w_rx_next;
  logic [IDX_W-1:0]  w_next_idx;
  logic              w_data_last;

  assign w_cmd_next  = {r_cmd_sr, w_copi};
  assign w_a_idx     = IDX_W'(w_cmd_next[ADDR_W-1:0]);
  assign w_addr_bad  = {1'b0, w_cmd_next[ADDR_W-1:0]} >= NUM_REGS_A;
  assign w_rx_next   = {r_rx, w_copi};
  assign w_next_idx  = (r_cur == IDX_LAST) ? '0 : r_cur + 1'b1;
  assign w_data_last = w_sclk_rise && (r_bit_cnt == DATA_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_cmd_sr    <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_skip      <= 1'b0;
      r_rw        <= 1'b0;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      r_cur       <= '0;
      // NOTE: the register file is explicitly reset because its contents are
      // architectural state seen on regs_out, not scratch storage.
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_ncs_fall) begin
            r_state   <= S_CMD;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end

        S_CMD: begin
          if (w_sclk_rise) begin
            r_cmd_sr  <= w_cmd_next[ADDR_W-1:0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == CMD_LAST) begin
              r_bit_cnt <= '0;
              r_rw      <= w_cmd_next[ADDR_W];
              if (w_addr_bad) begin
                r_frame_err <= 1'b1;
                r_state     <= S_DROP;
              end else begin
                r_cur   <= w_a_idx;
                r_state <= S_DATA;
                if (!w_cmd_next[ADDR_W]) begin
                  r_tx   <= r_regs[w_a_idx];
                  r_skip <= 1'b1;
                  r_oe   <= 1'b1;
                end
              end
            end
          end
          if (w_ncs_rise) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_oe    <= 1'b0;
            r_tx    <= '0;
            if (!(w_sclk_rise && r_bit_cnt == CMD_LAST)) r_frame_err <= 1'b1;
          end
        end

        S_DATA: begin
          if (w_sclk_rise) begin
            r_rx      <= w_rx_next[DATA_W-2:0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              r_cur     <= w_next_idx;
              if (r_rw) begin
                r_regs[r_cur] <= w_rx_next;
                r_wr_strobe   <= 1'b1;
                r_wr_addr     <= ADDR_W'(r_cur);
              end else begin
                r_tx   <= r_regs[w_next_idx];
                r_skip <= 1'b1;
              end
            end
          end
          if (w_sclk_fall && !r_rw) begin
            if (r_skip) r_skip <= 1'b0;
            else        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
          end
          // A word finishing on the same cycle as nCS rising still commits
          // above; only a genuinely partial word is an error.
          if (w_ncs_rise) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_oe    <= 1'b0;
            r_tx    <= '0;
            if ((r_bit_cnt != '0 || w_sclk_rise) && !w_data_last)
              r_frame_err <= 1'b1;
          end
        end

        S_DROP: begin
          if (w_ncs_rise) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_tx is only ever loaded on read frames and is cleared at frame end, so
  // its MSB is 0 during CMD, DROP and write frames.
  assign spi.cipo    = r_tx[DATA_W-1];
  assign spi.cipo_oe = r_oe;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign frame_err   = r_frame_err;
  assign busy        = r_busy;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_out[k*DATA_W +: DATA_W] = r_regs[k];
  end

endmodule

// File: tb/tb_spi_regfile_burst.sv
// ---------------------------------------------------------------------------
// tb_spi_regfile_burst
// Directed bench for spi_regfile_burst with default parameters (9 x 8 bits).
// Drives SPI mode-0 frames at clk/10 and compares the register bus, write
// strobes, error pulses and read-back data against hand-computed values.
// ---------------------------------------------------------------------------
module tb_spi_regfile_burst;
  localparam int NUM_REGS = 9;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;

  logic                       clk;
  logic                       rst;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;
  logic                       busy;

  spi_regfile_burst_if spi_bus ();

  spi_regfile_burst #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RESET_VAL('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi_bus.slave),
    .regs_out (regs_out),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling clock edge.
  int               strobe_cnt = 0;
  int               err_cnt    = 0;
  logic [ADDR_W-1:0] strobe_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe) begin
        strobe_cnt++;
        strobe_q.push_back(wr_addr);
      end
      if (frame_err) err_cnt++;
    end
  end

  logic [7:0] exp_regs [NUM_REGS];

  function automatic logic [NUM_REGS*DATA_W-1:0] packed_exp();
    logic [NUM_REGS*DATA_W-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = exp_regs[k];
    return v;
  endfunction

  // --- SPI master ---------------------------------------------------------
  task automatic spi_bit(input logic b, output logic rx, output logic oe);
    spi_bus.COPI = b;
    #50;
    rx = spi_bus.cipo;
    oe = spi_bus.cipo_oe;
    spi_bus.SCLK = 1'b1;
    #50;
    spi_bus.SCLK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    logic r, o;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, o);
      rx[i]  = r;
      oe_all = oe_all & o;
      oe_any = oe_any | o;
    end
  endtask

  task automatic cs_low();
    spi_bus.nCS = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #50;
    spi_bus.nCS = 1'b1;
    #200;
  endtask

  task automatic write_frame(input logic [7:0] cmd, input logic [7:0] d);
    logic [7:0] rx;
    logic a, b;
    cs_low();
    spi_byte(cmd, rx, a, b);
    spi_byte(d, rx, a, b);
    cs_high();
  endtask

  logic [7:0] rx0, rx1, rx_dummy;
  logic       oe_all0, oe_any0, oe_all1, oe_any1, oe_all2, oe_any2;
  logic       bit_rx, bit_oe;
  int         s0, e0;

  initial begin
    rst          = 1'b1;
    spi_bus.nCS  = 1'b1;
    spi_bus.SCLK = 1'b0;
    spi_bus.COPI = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 8'h00;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_regs",      regs_out,        packed_exp());
    check("rst_cipo",      spi_bus.cipo,    1'b0);
    check("rst_cipo_oe",   spi_bus.cipo_oe, 1'b0);
    check("rst_wr_strobe", wr_strobe,       1'b0);
    check("rst_frame_err", frame_err,       1'b0);
    check("rst_busy",      busy,            1'b0);
    rst = 1'b0;
    #200;

    // Single write: 1_0000100, 0xA5 -> reg4
    cs_low();
    spi_byte(8'h84, rx_dummy, oe_all0, oe_any0);
    check("wr1_busy", busy, 1'b1);
    spi_byte(8'hA5, rx_dummy, oe_all1, oe_any1);
    cs_high();
    exp_regs[4] = 8'hA5;
    check("wr1_regs",    regs_out,    packed_exp());
    check("wr1_strobes", strobe_cnt,  1);
    check("wr1_addr",    strobe_q[0], 7'd4);
    check("wr1_oe",      oe_any0 | oe_any1, 1'b0);
    check("wr1_busy_end", busy, 1'b0);
    check("wr1_err",     err_cnt, 0);

    // Burst write with wrap: 1_0000111, 0x11 0x22 0x33
    strobe_q.delete();
    cs_low();
    spi_byte(8'h87, rx_dummy, oe_all0, oe_any0);
    spi_byte(8'h11, rx_dummy, oe_all0, oe_any0);
    spi_byte(8'h22, rx_dummy, oe_all0, oe_any0);
    spi_byte(8'h33, rx_dummy, oe_all0, oe_any0);
    cs_high();
    exp_regs[7] = 8'h11;
    exp_regs[8] = 8'h22;
    exp_regs[0] = 8'h33;
    check("burst_regs",    regs_out,   packed_exp());
    check("burst_strobes", strobe_cnt, 4);
    check("burst_addr0",   (strobe_q.size() > 0) ? strobe_q[0] : 7'h7F, 7'd7);
    check("burst_addr1",   (strobe_q.size() > 1) ? strobe_q[1] : 7'h7F, 7'd8);
    check("burst_addr2",   (strobe_q.size() > 2) ? strobe_q[2] : 7'h7F, 7'd0);
    check("burst_err",     err_cnt, 0);

    // Read-back: preload reg2 = 0x3C, then read two words from address 2
    write_frame(8'h82, 8'h3C);
    exp_regs[2] = 8'h3C;
    s0 = strobe_cnt;
    cs_low();
    spi_byte(8'h02, rx_dummy, oe_all0, oe_any0);
    spi_byte(8'h00, rx0, oe_all1, oe_any1);
    spi_byte(8'h00, rx1, oe_all2, oe_any2);
    cs_high();
    check("rd_word0",     rx0, 8'h3C);
    check("rd_word1",     rx1, 8'h00);
    check("rd_oe_cmd",    oe_any0, 1'b0);
    check("rd_oe_data",   oe_all1 & oe_all2, 1'b1);
    check("rd_oe_after",  spi_bus.cipo_oe, 1'b0);
    check("rd_no_strobe", strobe_cnt, s0);
    check("rd_regs",      regs_out, packed_exp());

    // Read of a non-zero pattern at a wrap boundary: reg8 = 0x22 then reg0 = 0x33
    cs_low();
    spi_byte(8'h08, rx_dummy, oe_all0, oe_any0);
    spi_byte(8'h00, rx0, oe_all1, oe_any1);
    spi_byte(8'h00, rx1, oe_all2, oe_any2);
    cs_high();
    check("rdwrap_word0", rx0, 8'h22);
    check("rdwrap_word1", rx1, 8'h33);

    // Bad address: 1_0001001 (9), 0xFF
    e0 = err_cnt;
    s0 = strobe_cnt;
    cs_low();
    spi_byte(8'h89, rx_dummy, oe_all0, oe_any0);
    #100;
    check("bad_err_after_cmd", err_cnt, e0 + 1);
    spi_byte(8'hFF, rx_dummy, oe_all1, oe_any1);
    cs_high();
    check("bad_err_total", err_cnt, e0 + 1);
    check("bad_regs",      regs_out, packed_exp());
    check("bad_oe",        oe_any0 | oe_any1, 1'b0);
    check("bad_strobes",   strobe_cnt, s0);

    // Abort: 1_0000001 plus 5 data bits, then nCS high
    e0 = err_cnt;
    s0 = strobe_cnt;
    cs_low();
    spi_byte(8'h81, rx_dummy, oe_all0, oe_any0);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, bit_rx, bit_oe);
    cs_high();
    check("abort_err",     err_cnt, e0 + 1);
    check("abort_regs",    regs_out, packed_exp());
    check("abort_strobes", strobe_cnt, s0);
    write_frame(8'h81, 8'h0F);
    exp_regs[1] = 8'h0F;
    check("abort_next_regs", regs_out, packed_exp());
    check("abort_next_err",  err_cnt, e0 + 1);

    // Reset in the middle of a write to reg5 (prior value 0x77)
    write_frame(8'h85, 8'h77);
    exp_regs[5] = 8'h77;
    check("mid_pre_regs", regs_out, packed_exp());
    e0 = err_cnt;
    cs_low();
    spi_byte(8'h85, rx_dummy, oe_all0, oe_any0);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, bit_rx, bit_oe);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 8'h00;
    s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) spi_bit(1'b1, bit_rx, bit_oe);
    // Extra full word that must also be ignored
    spi_byte(8'hC3, rx_dummy, oe_all0, oe_any0);
    check("mid_busy_ignored", busy, 1'b0);
    cs_high();
    check("mid_regs",    regs_out, packed_exp());
    check("mid_strobes", strobe_cnt, s0);
    check("mid_err",     err_cnt, e0);
    write_frame(8'h85, 8'h5A);
    exp_regs[5] = 8'h5A;
    check("mid_next_regs",    regs_out, packed_exp());
    check("mid_next_strobes", strobe_cnt, s0 + 1);
    check("mid_next_addr",    strobe_q[strobe_q.size()-1], 7'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
